// File: rtl/piece_position_tracker_pkg.sv
// Shared tracker state encoding, default board geometry and small sizing helpers.
package piece_position_tracker_pkg;

  localparam int unsigned DEF_BOARD_W   = 10;
  localparam int unsigned DEF_BOARD_H   = 20;
  localparam int unsigned DEF_SPAWN_COL = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_ACTIVE,
    ST_LOCKED,
    ST_TOPOUT
  } trk_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/piece_position_tracker_if.sv
// Request/status bundle between the game-side logic and the piece position tracker.
interface piece_position_tracker_if #(
  parameter int unsigned LOC_W = 8
);
  logic             spawn_req;
  logic             spawn_blocked;
  logic             fall_tick;
  logic             collide_below;
  logic             move_valid;
  logic [LOC_W-1:0] move_loc;
  logic             drop_valid;
  logic [LOC_W-1:0] drop_loc;
  logic [LOC_W-1:0] location;
  logic [LOC_W-1:0] location_prev;
  logic             move_ack;
  logic             lock_pulse;
  logic             topout;
  logic             active;

  modport master (
    output spawn_req, spawn_blocked, fall_tick, collide_below,
           move_valid, move_loc, drop_valid, drop_loc,
    input  location, location_prev, move_ack, lock_pulse, topout, active
  );

  modport slave (
    input  spawn_req, spawn_blocked, fall_tick, collide_below,
           move_valid, move_loc, drop_valid, drop_loc,
    output location, location_prev, move_ack, lock_pulse, topout, active
  );
endinterface

// File: rtl/piece_position_tracker_lock_delay_counter.sv
// Grounded-tick lock counter plus the per-piece budget of move-triggered counter resets.
module piece_position_tracker_lock_delay_counter
  import piece_position_tracker_pkg::*;
#(
  parameter int unsigned LOCK_DELAY  = 2,
  parameter int unsigned LOCK_RESETS = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic grounded_i,
  input  logic move_reset_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned LW = cnt_width(LOCK_DELAY);
  localparam int unsigned RW = cnt_width(LOCK_RESETS);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [RW-1:0] reset_cnt_q, reset_cnt_d;

  always_comb begin
    lock_cnt_d  = lock_cnt_q;
    reset_cnt_d = reset_cnt_q;
    expire_o    = 1'b0;
    if (clear_i) begin
      lock_cnt_d  = '0;
      reset_cnt_d = '0;
    end else if (tick_i) begin
      if (!grounded_i) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q >= LW'(LOCK_DELAY - 1)) begin
        expire_o   = 1'b1;
      end else begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end else if (move_reset_i && (reset_cnt_q < RW'(LOCK_RESETS))) begin
      // Once the reset budget is spent, moves no longer postpone the lock.
      lock_cnt_d  = '0;
      reset_cnt_d = reset_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_q  <= '0;
      reset_cnt_q <= '0;
    end else begin
      lock_cnt_q  <= lock_cnt_d;
      reset_cnt_q <= reset_cnt_d;
    end
  end

endmodule

// File: rtl/piece_position_tracker.sv
// Active-piece anchor register with spawn retry, gravity, moves, hard drop, lock delay and top-out.
module piece_position_tracker
  import piece_position_tracker_pkg::*;
#(
  parameter int unsigned BOARD_W     = DEF_BOARD_W,
  parameter int unsigned BOARD_H     = DEF_BOARD_H,
  parameter int unsigned HIDDEN_ROWS = 2,
  parameter int unsigned SPAWN_COL   = DEF_SPAWN_COL,
  parameter int unsigned LOC_W       = 8,
  parameter int unsigned LOCK_DELAY  = 2,
  parameter int unsigned LOCK_RESETS = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  piece_position_tracker_if.slave  bus
);

  localparam int unsigned SPAWN_ROW = BOARD_H - 1;
  localparam int unsigned TOP_ROW   = SPAWN_ROW + HIDDEN_ROWS;
  localparam int unsigned NUM_CELLS = BOARD_W * (BOARD_H + HIDDEN_ROWS);
  localparam int unsigned ROW_W     = cnt_width(TOP_ROW);
  localparam logic [LOC_W-1:0] SPAWN_LOC = LOC_W'(SPAWN_ROW * BOARD_W + SPAWN_COL);
  localparam logic [LOC_W-1:0] STEP      = LOC_W'(BOARD_W);

  function automatic logic [ROW_W-1:0] row_of(input logic [LOC_W-1:0] l);
    return ROW_W'(32'(l) / BOARD_W);
  endfunction

  trk_state_e       state_q, state_d;
  logic [LOC_W-1:0] loc_q, loc_d, loc_prev_q;
  logic [ROW_W-1:0] row_q, row_d;
  logic             ack_q, ack_d;
  logic             lock_q, lock_d;
  logic             topout_q, topout_d;

  logic grounded, move_ok;
  logic cnt_tick, cnt_move, cnt_clear, expire;

  assign grounded  = bus.collide_below || (row_q == '0);
  assign move_ok   = 32'(bus.move_loc) < NUM_CELLS;
  assign cnt_clear = (state_q == ST_SPAWN) && !bus.spawn_blocked;
  assign cnt_tick  = (state_q == ST_ACTIVE) && !bus.drop_valid && bus.fall_tick;
  assign cnt_move  = (state_q == ST_ACTIVE) && !bus.drop_valid && !bus.fall_tick
                     && bus.move_valid && move_ok;

  piece_position_tracker_lock_delay_counter #(
    .LOCK_DELAY  (LOCK_DELAY),
    .LOCK_RESETS (LOCK_RESETS)
  ) u_lock_cnt (
    .clk          (clk),
    .rst          (rst),
    .tick_i       (cnt_tick),
    .grounded_i   (grounded),
    .move_reset_i (cnt_move),
    .clear_i      (cnt_clear),
    .expire_o     (expire)
  );

  always_comb begin
    state_d  = state_q;
    loc_d    = loc_q;
    row_d    = row_q;
    ack_d    = 1'b0;
    lock_d   = 1'b0;
    topout_d = topout_q;
    unique case (state_q)
      ST_IDLE, ST_LOCKED: begin
        if (bus.spawn_req) begin
          state_d = ST_SPAWN;
          loc_d   = SPAWN_LOC;
          row_d   = ROW_W'(SPAWN_ROW);
        end
      end
      ST_SPAWN: begin
        if (!bus.spawn_blocked) begin
          state_d = ST_ACTIVE;
        end else if (row_q < ROW_W'(TOP_ROW)) begin
          row_d = row_q + 1'b1;
          loc_d = loc_q + STEP;
        end else begin
          state_d  = ST_TOPOUT;
          topout_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Drop beats gravity beats move; a losing move simply gets no ack.
        if (bus.drop_valid) begin
          loc_d   = bus.drop_loc;
          row_d   = row_of(bus.drop_loc);
          lock_d  = 1'b1;
          state_d = ST_LOCKED;
        end else if (bus.fall_tick) begin
          if (!grounded) begin
            loc_d = loc_q - STEP;
            row_d = row_q - 1'b1;
          end else if (expire) begin
            lock_d  = 1'b1;
            state_d = ST_LOCKED;
          end
        end else if (cnt_move) begin
          loc_d = bus.move_loc;
          row_d = row_of(bus.move_loc);
          ack_d = 1'b1;
        end
      end
      ST_TOPOUT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      loc_q      <= SPAWN_LOC;
      loc_prev_q <= SPAWN_LOC;
      row_q      <= ROW_W'(SPAWN_ROW);
      ack_q      <= 1'b0;
      lock_q     <= 1'b0;
      topout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      loc_q      <= loc_d;
      loc_prev_q <= loc_q;
      row_q      <= row_d;
      ack_q      <= ack_d;
      lock_q     <= lock_d;
      topout_q   <= topout_d;
    end
  end

  assign bus.location      = loc_q;
  assign bus.location_prev = loc_prev_q;
  assign bus.move_ack      = ack_q;
  assign bus.lock_pulse    = lock_q;
  assign bus.topout        = topout_q;
  assign bus.active        = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_piece_position_tracker.sv
// Directed scenarios plus randomized traffic, checked every cycle against an integer reference model.
module tb_piece_position_tracker;

  localparam int W = 10;
  localparam int CELLS = 220;
  localparam int SPAWN = 194;
  localparam int TOP_HIDDEN_ROW = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piece_position_tracker_if #(.LOC_W(8)) bus ();

  piece_position_tracker #(
    .BOARD_W(10), .BOARD_H(20), .HIDDEN_ROWS(2), .SPAWN_COL(4),
    .LOC_W(8), .LOCK_DELAY(2), .LOCK_RESETS(15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: game phase plus plain integer location and counters.
  typedef enum int {M_IDLE, M_SPAWN, M_ACTIVE, M_LOCKED, M_TOPOUT} mode_e;
  mode_e m_mode;
  int m_loc, m_prev, m_lc, m_rc;
  bit m_ack, m_lock, m_top;

  task automatic model_edge();
    int row;
    bit grounded;
    m_prev = m_loc;
    m_ack  = 0;
    m_lock = 0;
    if (rst) begin
      m_mode = M_IDLE; m_loc = SPAWN; m_prev = SPAWN; m_top = 0;
      m_lc = 0; m_rc = 0;
      return;
    end
    row = m_loc / W;
    grounded = bus.collide_below || (row == 0);
    case (m_mode)
      M_IDLE, M_LOCKED: if (bus.spawn_req) begin m_mode = M_SPAWN; m_loc = SPAWN; end
      M_SPAWN: begin
        if (!bus.spawn_blocked) begin m_mode = M_ACTIVE; m_lc = 0; m_rc = 0; end
        else if (row < TOP_HIDDEN_ROW) m_loc += W;
        else begin m_mode = M_TOPOUT; m_top = 1; end
      end
      M_ACTIVE: begin
        if (bus.drop_valid) begin
          m_loc = int'(bus.drop_loc); m_lock = 1; m_mode = M_LOCKED;
        end else if (bus.fall_tick) begin
          if (!grounded) begin m_loc -= W; m_lc = 0; end
          else begin
            m_lc++;
            if (m_lc == 2) begin m_lock = 1; m_mode = M_LOCKED; end
          end
        end else if (bus.move_valid && int'(bus.move_loc) < CELLS) begin
          m_loc = int'(bus.move_loc); m_ack = 1;
          if (m_rc < 15) begin m_lc = 0; m_rc++; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic quiet();
    bus.spawn_req = 0; bus.spawn_blocked = 0; bus.fall_tick = 0; bus.collide_below = 0;
    bus.move_valid = 0; bus.move_loc = '0; bus.drop_valid = 0; bus.drop_loc = '0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("location", bus.location, m_loc);
    check("location_prev", bus.location_prev, m_prev);
    check("move_ack", bus.move_ack, m_ack);
    check("lock_pulse", bus.lock_pulse, m_lock);
    check("topout", bus.topout, m_top);
    check("active", bus.active, m_mode == M_ACTIVE);
  endtask

  task automatic respawn();
    quiet(); bus.spawn_req = 1; step();
    quiet(); step();
  endtask

  initial begin
    quiet();
    rst = 1; step();
    check("rst_loc", bus.location, 194);
    check("rst_active", bus.active, 0);
    rst = 0;

    // 1: spawn unblocked
    respawn();
    check("t1_loc", bus.location, 194);
    check("t1_active", bus.active, 1);

    // 2: free fall
    for (int i = 1; i <= 3; i++) begin
      quiet(); bus.fall_tick = 1; step();
      check("t2_loc", bus.location, 194 - 10 * i);
      check("t2_prev", bus.location_prev, 194 - 10 * (i - 1));
    end

    // 3: grounded lock after two ticks
    quiet(); bus.collide_below = 1; bus.fall_tick = 1; step();
    check("t3_nolock", bus.lock_pulse, 0);
    step();
    check("t3_lock", bus.lock_pulse, 1);
    check("t3_hold", bus.location, 164);
    respawn();
    check("t3_respawn", bus.active, 1);

    // 4: move resets lock counter
    quiet(); bus.collide_below = 1; bus.fall_tick = 1; step();
    quiet(); bus.collide_below = 1; bus.move_valid = 1; bus.move_loc = 8'd163; step();
    check("t4_ack", bus.move_ack, 1);
    check("t4_loc", bus.location, 163);
    quiet(); bus.collide_below = 1; bus.fall_tick = 1; step();
    check("t4_nolock", bus.lock_pulse, 0);
    step();
    check("t4_lock", bus.lock_pulse, 1);

    // 4b: reset budget runs out on the 16th move
    respawn();
    for (int i = 0; i < 15; i++) begin
      quiet(); bus.collide_below = 1; bus.move_valid = 1; bus.move_loc = 8'(150 + i); step();
    end
    quiet(); bus.collide_below = 1; bus.fall_tick = 1; step();
    quiet(); bus.collide_below = 1; bus.move_valid = 1; bus.move_loc = 8'd140; step();
    check("t4b_ack16", bus.move_ack, 1);
    quiet(); bus.collide_below = 1; bus.fall_tick = 1; step();
    check("t4b_lock", bus.lock_pulse, 1);

    // 5: drop beats tick and move
    respawn();
    quiet(); bus.drop_valid = 1; bus.drop_loc = 8'd4; bus.fall_tick = 1;
    bus.move_valid = 1; bus.move_loc = 8'd100; step();
    check("t5_loc", bus.location, 4);
    check("t5_lock", bus.lock_pulse, 1);
    check("t5_noack", bus.move_ack, 0);

    // 6: spawn retries into hidden rows then tops out
    quiet(); bus.spawn_req = 1; step();
    quiet(); bus.spawn_blocked = 1; step();
    check("t6_r20", bus.location, 204);
    step();
    check("t6_r21", bus.location, 214);
    step();
    check("t6_topout", bus.topout, 1);
    quiet(); bus.spawn_req = 1; step();
    check("t6_sticky", bus.topout, 1);
    check("t6_inactive", bus.active, 0);
    rst = 1; step();
    rst = 0;
    check("t6_rst_top", bus.topout, 0);
    check("t6_rst_loc", bus.location, 194);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      bus.spawn_req     = ($urandom_range(0, 3) == 0);
      bus.spawn_blocked = ($urandom_range(0, 5) == 0);
      bus.fall_tick     = ($urandom_range(0, 3) == 0);
      bus.collide_below = ($urandom_range(0, 2) == 0);
      bus.move_valid    = ($urandom_range(0, 1) == 0);
      bus.move_loc      = 8'($urandom_range(0, 255));
      bus.drop_valid    = ($urandom_range(0, 19) == 0);
      bus.drop_loc      = 8'($urandom_range(0, CELLS - 1));
      step();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
